// File: rtl/a_loader.sv
// Activation loader: streams column-major beats into ARRAY_N lane RAMs.
// The RAMs share one address/data bus and each lane has its own write enable.
module a_loader #(
   parameter int unsigned RAM_SIZE   = 1024,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
   parameter int unsigned ARRAY_N    = 8,
   parameter int unsigned ACT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        clear,
   input  logic [ADDR_WIDTH-1:0]       base_addr,
   input  logic [$clog2(ARRAY_N):0]    num_rows,
   input  logic [ADDR_WIDTH:0]         num_cols,
   input  logic                        in_valid,
   input  logic [ACT_WIDTH-1:0]        in_data,
   output logic                        in_ready,
   output logic [ADDR_WIDTH-1:0]       bram_to_ram_w_addr,
   output logic [ARRAY_N-1:0]          bram_to_ram_w_en,
   output logic [ACT_WIDTH-1:0]        bram_to_ram_w_data,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned ROW_W  = $clog2(ARRAY_N) + 1;
   localparam int unsigned LANE_W = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
   localparam int unsigned COL_W  = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                 state, state_next;
   logic [ADDR_WIDTH-1:0]  base_q;
   logic [ROW_W-1:0]       rows_q;
   logic [COL_W-1:0]       cols_q;
   logic [LANE_W-1:0]      lane_q;
   logic [COL_W-1:0]       col_q;

   logic [ROW_W-1:0]       rows_clamped_c;
   logic                   accept_c;
   logic                   lane_last_c;
   logic                   col_last_c;
   logic                   take_start_c;

   // Datapath decode shared by the FSM and the counters
   always_comb begin
      rows_clamped_c = (num_rows > ROW_W'(ARRAY_N)) ? ROW_W'(ARRAY_N) : num_rows;
      accept_c       = in_ready && in_valid && !clear;
      lane_last_c    = (ROW_W'(lane_q) == rows_q - ROW_W'(1));
      col_last_c     = (col_q == cols_q - COL_W'(1));
      take_start_c   = (state == IDLE) && start && !clear;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; clear overrides every other transition
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               if (rows_clamped_c == '0 || num_cols == '0) state_next = DONE;
               else                                        state_next = LOAD;
            end
         end
         LOAD: begin
            if (accept_c && lane_last_c && col_last_c) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Job parameters and lane/column counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q <= '0;
         rows_q <= '0;
         cols_q <= '0;
         lane_q <= '0;
         col_q  <= '0;
      end else if (clear) begin
         lane_q <= '0;
         col_q  <= '0;
      end else if (take_start_c) begin
         base_q <= base_addr;
         rows_q <= rows_clamped_c;
         cols_q <= num_cols;
         lane_q <= '0;
         col_q  <= '0;
      end else if (accept_c) begin
         if (lane_last_c) begin
            lane_q <= '0;
            col_q  <= col_q + COL_W'(1);
         end else begin
            lane_q <= lane_q + LANE_W'(1);
         end
      end
   end

   // Registered outputs; write bus lags the accepted beat by one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready           <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         bram_to_ram_w_en   <= '0;
         bram_to_ram_w_addr <= '0;
         bram_to_ram_w_data <= '0;
      end else begin
         in_ready         <= (state_next == LOAD);
         busy             <= (state_next == LOAD);
         done             <= (state_next == DONE);
         bram_to_ram_w_en <= accept_c ? (ARRAY_N'(1) << lane_q) : '0;
         if (accept_c) begin
            bram_to_ram_w_addr <= base_q + ADDR_WIDTH'(col_q);
            bram_to_ram_w_data <= in_data;
         end
      end
   end

endmodule

// File: doc/a_loader.md
A_LOADER -- requirements
Module: a_loader

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 1024, depth of each activation RAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_SIZE), RAM address width.
REQ-003 SHALL have parameter ARRAY_N, default 8, number of activation RAM lanes (array rows).
REQ-004 SHALL have parameter ACT_WIDTH, default 8, activation element width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle load request, sampled in IDLE only.
REQ-008 SHALL have port clear  input  1  synchronous abort back to IDLE.
REQ-009 SHALL have port base_addr  input  ADDR_WIDTH  first RAM address written.
REQ-010 SHALL have port num_rows  input  $clog2(ARRAY_N)+1  lanes to fill.
REQ-011 SHALL have port num_cols  input  ADDR_WIDTH+1  addresses per lane to fill.
REQ-012 SHALL have port in_valid  input  1  stream beat valid.
REQ-013 SHALL have port in_data  input  ACT_WIDTH  stream activation element.
REQ-014 SHALL have port in_ready  output  1  stream beat accepted when in_valid && in_ready.
REQ-015 SHALL have port bram_to_ram_w_addr  output  ADDR_WIDTH  shared RAM write address.
REQ-016 SHALL have port bram_to_ram_w_en  output  ARRAY_N  one-hot per-lane write enable.
REQ-017 SHALL have port bram_to_ram_w_data  output  ACT_WIDTH  shared RAM write data.
REQ-018 SHALL have ports busy  output  1  high in LOAD, and done  output  1  one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-020 IDLE: on start, SHALL register base_addr, num_rows clamped to ARRAY_N, num_cols; clear lane and column counters.
REQ-021 IDLE with start and (num_rows==0 or num_cols==0) SHALL go to DONE with zero writes.
REQ-022 IDLE with start and nonzero sizes SHALL go to LOAD.
REQ-023 start in LOAD or DONE SHALL be ignored.
REQ-024 in_ready SHALL equal 1 only in LOAD; busy SHALL equal 1 only in LOAD.
REQ-025 Stream order SHALL be column-major: per column c, lanes 0..num_rows-1, then c+1.
REQ-026 Each accepted beat (lane l, column c) SHALL produce, exactly one cycle later, w_en = one-hot bit l, w_addr = (base_addr + c) mod 2^ADDR_WIDTH, w_data = in_data.
REQ-027 w_en SHALL be all-zero in any cycle following a cycle without an accepted beat; w_addr/w_data hold their last values.
REQ-028 Lane counter SHALL wrap to 0 after num_rows-1 and increment the column counter.
REQ-029 Acceptance of beat (num_rows-1, num_cols-1) SHALL move to DONE; total beats = num_rows*num_cols.
REQ-030 DONE SHALL assert done for exactly one cycle, coinciding with the final w_en pulse (or the cycle after start for zero-size), then go to IDLE.
REQ-031 Address wrap-around past RAM_SIZE-1 SHALL be modulo 2^ADDR_WIDTH with no error.
REQ-032 clear SHALL take priority over all events: next state IDLE, no done, w_en zero next cycle, a beat accepted in the clear cycle is discarded.
REQ-033 in_valid low in LOAD SHALL stall counters without losing state.

Reset
REQ-034 reset low SHALL immediately force IDLE, counters 0, in_ready 0, busy 0, done 0, w_en 0, w_addr 0, w_data 0.
REQ-035 reset assertion mid-LOAD SHALL abandon the load; no done pulse after release.
REQ-036 Outputs SHALL leave reset values only on the first rising clk edge after reset deassertion.

Verification
REQ-037 ARRAY_N=8, base 0x010, rows 8, cols 2, 16 back-to-back beats 0x01..0x10 -> w_en 0x01..0x80 at addr 0x010 with data 0x01..0x08, then 0x01..0x80 at 0x011 with 0x09..0x10; done with last write.
REQ-038 rows 3, cols 4, in_valid toggled every other cycle -> exactly 12 writes, lanes 0..2 only, addrs base..base+3, no w_en during gaps.
REQ-039 base 0x3FE, rows 1, cols 4 -> writes at 0x3FE, 0x3FF, 0x000, 0x001 on lane 0.
REQ-040 start with num_cols=0 -> no writes, done pulse next cycle, in_ready never high; num_rows=12 -> clamped to 8 lanes.
REQ-041 clear after 5 of 16 beats -> 5 writes only, IDLE, no done; subsequent start runs cleanly from base.
REQ-042 reset low mid-LOAD -> all outputs zero asynchronously, no done after release, start accepted afterward.
